// File: rtl/core_selftest_pkg.sv
// rtl/core_selftest_pkg.sv - shared state encoding and default parameters for the core self-test sequencer
package core_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD1 = 3'd1,
    ST_LOAD2 = 3'd2,
    ST_RUN   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int unsigned DEF_XLEN      = 64;
  localparam int unsigned DEF_REG_AW    = 5;
  localparam int unsigned DEF_NUM_TESTS = 8;
  localparam int unsigned DEF_TIMEOUT   = 16;

  // Index ports keep at least one bit even for a single-vector table.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/selftest_timeout_ctr.sv
// rtl/selftest_timeout_ctr.sv - loadable RUN-phase down-counter with expiry flag
module selftest_timeout_ctr
  import core_selftest_pkg::*;
#(
  parameter  int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry marks the last permitted RUN cycle, not the cycle after it.
  assign expired_o = (cnt_q == CW'(1));

endmodule

// File: rtl/core_selftest_seq.sv
// rtl/core_selftest_seq.sv - runs the directed test-vector table against the core via debug write, restart and writeback
module core_selftest_seq
  import core_selftest_pkg::*;
#(
  parameter  int unsigned XLEN      = DEF_XLEN,
  parameter  int unsigned REG_AW    = DEF_REG_AW,
  parameter  int unsigned NUM_TESTS = DEF_NUM_TESTS,
  parameter  int unsigned TIMEOUT   = DEF_TIMEOUT,
  localparam int unsigned IW        = idx_width(NUM_TESTS),
  localparam int unsigned FW        = $clog2(NUM_TESTS + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [FW-1:0]     fail_count_o,
  output logic [IW-1:0]     first_fail_o,
  output logic [IW-1:0]     vec_idx_o,
  input  logic [XLEN-1:0]   vec_pc_i,
  input  logic [REG_AW-1:0] vec_rs1_i,
  input  logic [REG_AW-1:0] vec_rs2_i,
  input  logic [XLEN-1:0]   vec_rs1_val_i,
  input  logic [XLEN-1:0]   vec_rs2_val_i,
  input  logic [REG_AW-1:0] vec_exp_rd_i,
  input  logic [XLEN-1:0]   vec_exp_data_i,
  output logic              core_hold_o,
  output logic              core_restart_o,
  output logic [XLEN-1:0]   restart_pc_o,
  output logic              dbg_we_o,
  output logic [REG_AW-1:0] dbg_waddr_o,
  output logic [XLEN-1:0]   dbg_wdata_o,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i
);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [IW-1:0]   ffirst_q, ffirst_d;
  logic            fail_q, fail_d;
  logic            ctr_load;
  logic            expired;
  logic            wb_hit;

  selftest_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (ctr_load),
    .en_i      (state_q == ST_RUN),
    .expired_o (expired)
  );

  assign wb_hit = wb_valid_i && (wb_rd_i == vec_exp_rd_i);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    ffirst_d    = ffirst_q;
    fail_d      = fail_q;
    ctr_load    = 1'b0;
    dbg_we_o    = 1'b0;
    dbg_waddr_o = '0;
    dbg_wdata_o = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d  = ST_LOAD1;
          idx_d    = '0;
          fcnt_d   = '0;
          ffirst_d = '0;
        end
      end
      ST_LOAD1: begin
        dbg_we_o    = (vec_rs1_i != '0) && !reset_i;
        dbg_waddr_o = vec_rs1_i;
        dbg_wdata_o = vec_rs1_val_i;
        state_d     = ST_LOAD2;
      end
      ST_LOAD2: begin
        dbg_we_o    = (vec_rs2_i != '0) && !reset_i;
        dbg_waddr_o = vec_rs2_i;
        dbg_wdata_o = vec_rs2_val_i;
        fail_d      = 1'b0;
        ctr_load    = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (vec_exp_rd_i != '0) begin
          // A matching writeback wins over expiry in the same cycle.
          if (wb_hit) begin
            fail_d  = (wb_data_i != vec_exp_data_i);
            state_d = ST_CHECK;
          end else if (expired) begin
            fail_d  = 1'b1;
            state_d = ST_CHECK;
          end
        end else begin
          if (wb_valid_i && (wb_rd_i != '0)) begin
            fail_d = 1'b1;
          end
          if (expired) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (fail_q) begin
          fcnt_d = fcnt_q + FW'(1);
          if (fcnt_q == '0) begin
            ffirst_d = idx_q;
          end
        end
        if (idx_q == IW'(NUM_TESTS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_LOAD1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      fcnt_q   <= '0;
      ffirst_q <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      ffirst_q <= ffirst_d;
      fail_q   <= fail_d;
    end
  end

  assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o         = (state_q == ST_DONE);
  assign pass_o         = done_o && (fcnt_q == '0);
  assign fail_count_o   = fcnt_q;
  assign first_fail_o   = ffirst_q;
  assign vec_idx_o      = idx_q;
  assign core_hold_o    = (state_q != ST_RUN);
  assign core_restart_o = (state_q == ST_LOAD1);
  assign restart_pc_o   = vec_pc_i;

endmodule

// File: tb/tb_core_selftest_seq.sv
// tb/tb_core_selftest_seq.sv - self-checking bench for core_selftest_seq with a behavioural core and sequencer model
module tb_core_selftest_seq;

  localparam int N = 8;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, pass;
  logic [3:0]  fail_count;
  logic [2:0]  first_fail, vec_idx;
  logic [63:0] vec_pc, vec_rs1_val, vec_rs2_val, vec_exp_data;
  logic [4:0]  vec_rs1, vec_rs2, vec_exp_rd;
  logic        core_hold, core_restart;
  logic [63:0] restart_pc;
  logic        dbg_we;
  logic [4:0]  dbg_waddr;
  logic [63:0] dbg_wdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [63:0] rs1v;
    logic [4:0]  rs2;
    logic [63:0] rs2v;
    logic [4:0]  erd;
    logic [63:0] edata;
    int          wc;
    logic [4:0]  wrd;
    logic [63:0] wdat;
    int          sc;
    logic [4:0]  srd;
  } vec_t;

  vec_t         rom [N];
  logic [127:0] expq [$];
  int           run_len [N];
  int           busy_len [N];
  int           checks = 0;
  int           passes = 0;
  int           fc_m, ff_m;

  always #5 clk = ~clk;

  core_selftest_seq #(.XLEN(64), .REG_AW(5), .NUM_TESTS(N), .TIMEOUT(T)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .fail_count_o(fail_count), .first_fail_o(first_fail), .vec_idx_o(vec_idx),
    .vec_pc_i(vec_pc), .vec_rs1_i(vec_rs1), .vec_rs2_i(vec_rs2),
    .vec_rs1_val_i(vec_rs1_val), .vec_rs2_val_i(vec_rs2_val),
    .vec_exp_rd_i(vec_exp_rd), .vec_exp_data_i(vec_exp_data),
    .core_hold_o(core_hold), .core_restart_o(core_restart), .restart_pc_o(restart_pc),
    .dbg_we_o(dbg_we), .dbg_waddr_o(dbg_waddr), .dbg_wdata_o(dbg_wdata),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data)
  );

  assign vec_pc       = rom[vec_idx].pc;
  assign vec_rs1      = rom[vec_idx].rs1;
  assign vec_rs1_val  = rom[vec_idx].rs1v;
  assign vec_rs2      = rom[vec_idx].rs2;
  assign vec_rs2_val  = rom[vec_idx].rs2v;
  assign vec_exp_rd   = rom[vec_idx].erd;
  assign vec_exp_data = rom[vec_idx].edata;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [127:0] pack(input logic b, input logic h, input logic r, input logic w,
                                        input logic [4:0] wa, input logic [63:0] wd, input logic [2:0] ix,
                                        input logic dn, input logic ps, input logic [3:0] fc, input logic [2:0] ff);
    return {43'd0, b, h, r, w, wa, wd, ix, dn, ps, fc, ff};
  endfunction

  // Core model: what the core writes back in RUN cycle k of a vector.
  task automatic w_at(input vec_t v, input int k, output logic wv, output logic [4:0] wr, output logic [63:0] wd);
    wv = 1'b0; wr = '0; wd = '0;
    if (v.wc == k) begin
      wv = 1'b1; wr = v.wrd; wd = v.wdat;
    end else if (v.sc == k) begin
      wv = 1'b1; wr = v.srd;
    end
  endtask

  // Sequencer model: RUN length and verdict for one vector.
  task automatic model(input vec_t v, output int r, output bit f);
    logic wv; logic [4:0] wr; logic [63:0] wd;
    int hit;
    hit = 0; r = T; f = 1'b0;
    for (int k = 1; k <= T; k++) begin
      w_at(v, k, wv, wr, wd);
      if (v.erd != 0) begin
        if (hit == 0 && wv && wr == v.erd) begin
          hit = k; r = k; f = (wd != v.edata);
        end
      end else if (wv && wr != 0) begin
        f = 1'b1;
      end
    end
    if (v.erd != 0 && hit == 0) f = 1'b1;
  endtask

  task automatic build(output int fc, output int ff);
    int r; bit f;
    fc = 0; ff = 0;
    for (int i = 0; i < N; i++) begin
      model(rom[i], r, f);
      expq.push_back(pack(1, 1, 1, rom[i].rs1 != 0, rom[i].rs1, rom[i].rs1v, 3'(i), 0, 0, 4'(fc), 3'(ff)));
      expq.push_back(pack(1, 1, 0, rom[i].rs2 != 0, rom[i].rs2, rom[i].rs2v, 3'(i), 0, 0, 4'(fc), 3'(ff)));
      repeat (r) expq.push_back(pack(1, 0, 0, 0, 0, 0, 3'(i), 0, 0, 4'(fc), 3'(ff)));
      expq.push_back(pack(1, 1, 0, 0, 0, 0, 3'(i), 0, 0, 4'(fc), 3'(ff)));
      if (f) begin
        if (fc == 0) ff = i;
        fc++;
      end
    end
    repeat (2) expq.push_back(pack(0, 1, 0, 0, 0, 0, 3'(N - 1), 1, fc == 0, 4'(fc), 3'(ff)));
  endtask

  task automatic set_vec(input int i, input logic [63:0] pc, input logic [4:0] rs1, input logic [63:0] rs1v,
                         input logic [4:0] rs2, input logic [63:0] rs2v, input logic [4:0] erd,
                         input logic [63:0] edata, input int wc, input logic [4:0] wrd,
                         input logic [63:0] wdat, input int sc, input logic [4:0] srd);
    rom[i].pc = pc; rom[i].rs1 = rs1; rom[i].rs1v = rs1v; rom[i].rs2 = rs2; rom[i].rs2v = rs2v;
    rom[i].erd = erd; rom[i].edata = edata; rom[i].wc = wc; rom[i].wrd = wrd; rom[i].wdat = wdat;
    rom[i].sc = sc; rom[i].srd = srd;
  endtask

  task automatic campaign(input bit poke_busy, output int fc, output int ff);
    int g;
    @(negedge clk);
    start = 1'b1;
    build(fc, ff);
    @(negedge clk);
    start = 1'b0;
    if (poke_busy) begin
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    g = 0;
    while (expq.size() > 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("campaign_complete", expq.size() == 0, 1'b1);
    expq.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_hold"}, core_hold, 1'b1);
    chk({tag, "_restart"}, core_restart, 1'b0);
    chk({tag, "_dbg_we"}, dbg_we, 1'b0);
    chk({tag, "_dbg_addr_data"}, {dbg_waddr, dbg_wdata}, 69'd0);
    chk({tag, "_counts"}, {fail_count, first_fail, vec_idx}, 10'd0);
  endtask

  // Per-cycle compare of every registered/decoded output against the model trace.
  initial begin
    logic [127:0] e;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk($sformatf("trace_cycle_%0d", cyc),
            pack(busy, core_hold, core_restart, dbg_we, dbg_waddr, dbg_wdata, vec_idx, done, pass,
                 fail_count, first_fail), e);
        if (core_restart) chk($sformatf("restart_pc_%0d", cyc), restart_pc, rom[vec_idx].pc);
        cyc++;
      end
    end
  end

  // Core model driving the writeback bus during RUN.
  initial begin
    int rc, bc;
    logic wv; logic [4:0] wr; logic [63:0] wd;
    rc = 0; bc = 0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    forever begin
      @(negedge clk);
      if (core_restart) begin
        rc = 0; bc = 0;
      end
      if (busy) begin
        bc++;
        busy_len[vec_idx] = bc;
      end
      wv = 1'b0; wr = '0; wd = '0;
      if (!core_hold && !reset) begin
        rc++;
        run_len[vec_idx] = rc;
        w_at(rom[vec_idx], rc, wv, wr, wd);
      end
      wb_valid = wv; wb_rd = wr; wb_data = wd;
    end
  end

  initial begin
    int g;
    reset = 1'b1;
    start = 1'b0;
    set_vec(0, 64'h1000, 1, 10, 2, 5, 3, 15, 2, 3, 15, 1, 4);
    set_vec(1, 64'h1004, 1, 9, 2, 4, 3, 5, 1, 3, 4, 0, 0);
    set_vec(2, 64'h1008, 2, 7, 6, 8, 0, 0, 0, 0, 0, 0, 0);
    set_vec(3, 64'h100c, 2, 7, 6, 8, 0, 0, 0, 0, 0, 5, 7);
    set_vec(4, 64'h1010, 0, 99, 4, 1, 5, 100, 1, 5, 100, 0, 0);
    set_vec(5, 64'h1014, 1, 1, 2, 2, 3, 3, 0, 0, 0, 3, 7);
    set_vec(6, 64'h1018, 1, 1, 2, 2, 31, 64'hFFFF_FFFF_FFFF_FFFF, 16, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    set_vec(7, 64'h101c, 8, 1, 9, 2, 8, 64'h8000_0000_0000_0001, 3, 8, 64'h1, 0, 0);
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;

    campaign(1'b0, fc_m, ff_m);
    chk("A_model_fail_count", fc_m, 4);
    chk("A_model_first_fail", ff_m, 1);
    chk("A_fail_count", fail_count, 4'd4);
    chk("A_first_fail", first_fail, 3'd1);
    chk("A_pass", pass, 1'b0);
    chk("A_done", done, 1'b1);
    chk("A_t0_busy_cycles", busy_len[0], 5);
    chk("A_t0_run", run_len[0], 2);
    chk("A_store_run", run_len[2], 16);
    chk("A_x0_run", run_len[4], 1);
    chk("A_timeout_run", run_len[5], 16);
    chk("A_lastcycle_run", run_len[6], 16);
    chk("A_msb_run", run_len[7], 3);

    for (int i = 0; i < N; i++)
      set_vec(i, 64'h2000 + 64'(4 * i), 5'(i + 1), 64'(3 * i), 5'(i + 10), 7, 5'(i + 1),
              64'h100 + 64'(i), (i % 3) + 1, 5'(i + 1), 64'h100 + 64'(i), 0, 0);
    rom[2].wdat = 64'h103;
    rom[5].wc = 0;
    campaign(1'b1, fc_m, ff_m);
    chk("B_model_fail_count", fc_m, 2);
    chk("B_model_first_fail", ff_m, 2);
    chk("B_fail_count", fail_count, 4'd2);
    chk("B_first_fail", first_fail, 3'd2);
    chk("B_pass", pass, 1'b0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(vec_idx == 3'd4 && !core_hold) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("reach_run_of_test4", g < 500, 1'b1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check_reset("abort");
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_abort_busy", busy, 1'b0);

    campaign(1'b0, fc_m, ff_m);
    chk("C_fail_count", fail_count, 4'd2);
    chk("C_first_fail", first_fail, 3'd2);
    chk("C_done", done, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
